id_ex_stage: RTL and testbench

ID/EX pipeline register plus the EX-stage operand front end that feeds the 32-bit ALU.
- Captures decoded ID-stage fields each clock.
- Resolves data hazards by forwarding from EX/MEM and MEM/WB.
- Applies the ALUSrc immediate mux and decodes ALUOp/funct into the 3-bit ALU control.
- Drives a, b and control into the ALU combinationally, and passes the control bits through to EX/MEM.

---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/alu_control.sv | 32 +++
 rtl/id_ex_stage.sv | 141 ++++++++++++++
 tb/tb_id_ex_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: ALUOp, ALU control, funct and forward-select codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  // ALUOp field produced by the main decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_X     = 2'b11
  } aluop_e;

  // ALU control codes, shared with the ALU itself; ALU_X makes the ALU emit all-X
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_X   = 3'b011,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctl_e;

  // R-type funct field values (imm[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Operand source chosen by the forwarding logic
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  // Pipeline control bits carried from ID through EX to later stages
  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ex_ctrl_t;

endpackage

// File: rtl/alu_control.sv
// ALU control decode from ALUOp and the R-type funct field.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module alu_control
  import pipe_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] control
);

  // Map ALUOp (and funct for R-type) onto the ALU control code; unknown ops give ALU_X
  always_comb begin
    control = ALU_X;
    case (aluop)
      ALUOP_ADD: control = ALU_ADD;
      ALUOP_SUB: control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: control = ALU_ADD;
          FUNCT_SUB: control = ALU_SUB;
          FUNCT_AND: control = ALU_AND;
          FUNCT_OR:  control = ALU_OR;
          FUNCT_SLT: control = ALU_SLT;
          default:   control = ALU_X;
        endcase
      end
      default: control = ALU_X;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus EX operand front end (forwarding, ALUSrc mux, ALU control).
// Latency: one clock from id_* capture; outputs then combinational from regs and exmem/memwb inputs.
// Backpressure: stall holds every registered field; flush (or rst) loads an all-zero bubble.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic [WIDTH-1:0]    id_rs_data,
  input  logic [WIDTH-1:0]    id_rt_data,
  input  logic [15:0]         id_imm,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic [1:0]          id_aluop,
  input  logic                id_alusrc,
  input  logic                id_regdst,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic                id_memwrite,
  input  logic                id_memtoreg,
  input  logic                exmem_regwrite,
  input  logic [REG_BITS-1:0] exmem_rd,
  input  logic [WIDTH-1:0]    exmem_result,
  input  logic                memwb_regwrite,
  input  logic [REG_BITS-1:0] memwb_rd,
  input  logic [WIDTH-1:0]    memwb_result,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [2:0]          alu_control,
  output logic [WIDTH-1:0]    ex_store_data,
  output logic [REG_BITS-1:0] ex_dest,
  output logic                ex_regwrite,
  output logic                ex_memread,
  output logic                ex_memwrite,
  output logic                ex_memtoreg
);

  // Everything the EX stage needs about the instruction it is executing
  typedef struct packed {
    logic [WIDTH-1:0]    rs_data;
    logic [WIDTH-1:0]    rt_data;
    logic [15:0]         imm;
    logic [REG_BITS-1:0] rs;
    logic [REG_BITS-1:0] rt;
    logic [REG_BITS-1:0] rd;
    logic [1:0]          aluop;
    logic                alusrc;
    logic                regdst;
    ex_ctrl_t            ctrl;
  } idex_t;

  idex_t            idex_q;
  idex_t            idex_d;
  fwd_sel_e         sel_a;
  fwd_sel_e         sel_b;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] imm_ext;

  // A register-0 destination never forwards; EX/MEM is younger so it wins over MEM/WB
  function automatic fwd_sel_e fwd_pick(input logic [REG_BITS-1:0] src);
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src))
      return FWD_EXMEM;
    else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src))
      return FWD_MEMWB;
    else
      return FWD_REG;
  endfunction

  // Gather the ID-stage fields into the register image
  always_comb begin
    idex_d               = '0;
    idex_d.rs_data       = id_rs_data;
    idex_d.rt_data       = id_rt_data;
    idex_d.imm           = id_imm;
    idex_d.rs            = id_rs;
    idex_d.rt            = id_rt;
    idex_d.rd            = id_rd;
    idex_d.aluop         = id_aluop;
    idex_d.alusrc        = id_alusrc;
    idex_d.regdst        = id_regdst;
    idex_d.ctrl.regwrite = id_regwrite;
    idex_d.ctrl.memread  = id_memread;
    idex_d.ctrl.memwrite = id_memwrite;
    idex_d.ctrl.memtoreg = id_memtoreg;
  end

  // Pipeline register: reset and flush both insert a bubble, stall holds
  always_ff @(posedge clk) begin
    if (rst || flush)
      idex_q <= '0;
    else if (!stall)
      idex_q <= idex_d;
  end

  // Hazard detection for both source operands
  always_comb begin
    sel_a = fwd_pick(idex_q.rs);
    sel_b = fwd_pick(idex_q.rt);
  end

  // Forwarding muxes select the freshest copy of rs and rt
  always_comb begin
    fwd_a = idex_q.rs_data;
    fwd_b = idex_q.rt_data;
    case (sel_a)
      FWD_EXMEM: fwd_a = exmem_result;
      FWD_MEMWB: fwd_a = memwb_result;
      default:   fwd_a = idex_q.rs_data;
    endcase
    case (sel_b)
      FWD_EXMEM: fwd_b = exmem_result;
      FWD_MEMWB: fwd_b = memwb_result;
      default:   fwd_b = idex_q.rt_data;
    endcase
  end

  assign imm_ext       = {{(WIDTH-16){idex_q.imm[15]}}, idex_q.imm};
  assign alu_a         = fwd_a;
  assign alu_b         = idex_q.alusrc ? imm_ext : fwd_b;
  // Stores always need the forwarded rt value even though b carries the offset
  assign ex_store_data = fwd_b;
  assign ex_dest       = idex_q.regdst ? idex_q.rd : idex_q.rt;
  assign ex_regwrite   = idex_q.ctrl.regwrite;
  assign ex_memread    = idex_q.ctrl.memread;
  assign ex_memwrite   = idex_q.ctrl.memwrite;
  assign ex_memtoreg   = idex_q.ctrl.memtoreg;

  alu_control u_alu_control (
    .aluop   (idex_q.aluop),
    .funct   (idex_q.imm[5:0]),
    .control (alu_control)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage with a scoreboard fed by a behavioural model.
// Latency: expectations are pushed at each rising edge and checked 2 time units later.
// Backpressure: stall/flush/rst are driven directly, both directed and random.
module tb_id_ex_stage;

  typedef struct packed {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  aluop;
    logic        alusrc;
    logic        regdst;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
  } instr_t;

  typedef struct packed {
    logic        ex_we;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
  } fw_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic [4:0]  dest;
    logic [2:0]  ctl;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        mt;
  } exp_t;

  logic clk;
  logic rst, stall, flush;
  instr_t d_in, nx;
  fw_t    d_fw, nfw;
  instr_t model;
  exp_t   sb[$];

  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_control;
  logic [4:0]  ex_dest;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

  int n_chk  = 0;
  int n_fail = 0;

  logic [5:0] funct_key [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] funct_val [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

  id_ex_stage #(.WIDTH(32), .REG_BITS(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .id_rs_data     (d_in.rs_data),
    .id_rt_data     (d_in.rt_data),
    .id_imm         (d_in.imm),
    .id_rs          (d_in.rs),
    .id_rt          (d_in.rt),
    .id_rd          (d_in.rd),
    .id_aluop       (d_in.aluop),
    .id_alusrc      (d_in.alusrc),
    .id_regdst      (d_in.regdst),
    .id_regwrite    (d_in.regwrite),
    .id_memread     (d_in.memread),
    .id_memwrite    (d_in.memwrite),
    .id_memtoreg    (d_in.memtoreg),
    .exmem_regwrite (d_fw.ex_we),
    .exmem_rd       (d_fw.ex_rd),
    .exmem_result   (d_fw.ex_res),
    .memwb_regwrite (d_fw.wb_we),
    .memwb_rd       (d_fw.wb_rd),
    .memwb_result   (d_fw.wb_res),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_control    (alu_control),
    .ex_store_data  (ex_store_data),
    .ex_dest        (ex_dest),
    .ex_regwrite    (ex_regwrite),
    .ex_memread     (ex_memread),
    .ex_memwrite    (ex_memwrite),
    .ex_memtoreg    (ex_memtoreg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Value a source register reads in EX: the youngest in-flight writer, else the register file copy
  function automatic logic [31:0] operand(input logic [4:0] src, input logic [31:0] own, input fw_t f);
    if (src == 5'd0) return own;
    if (f.ex_we && f.ex_rd == src) return f.ex_res;
    if (f.wb_we && f.wb_rd == src) return f.wb_res;
    return own;
  endfunction

  function automatic logic [2:0] ctl_of(input logic [1:0] op, input logic [15:0] imm);
    logic [2:0] c;
    c = 3'b011;
    if (op == 2'd0) c = 3'b010;
    else if (op == 2'd1) c = 3'b110;
    else if (op == 2'd2)
      for (int k = 0; k < 5; k++)
        if (imm[5:0] == funct_key[k]) c = funct_val[k];
    return c;
  endfunction

  function automatic exp_t expect_of(input instr_t m, input fw_t f);
    exp_t e;
    logic [31:0] ra, rb, imm32;
    ra     = operand(m.rs, m.rs_data, f);
    rb     = operand(m.rt, m.rt_data, f);
    imm32  = 32'(signed'(m.imm));
    e.a    = ra;
    e.b    = m.alusrc ? imm32 : rb;
    e.st   = rb;
    e.dest = m.regdst ? m.rd : m.rt;
    e.ctl  = ctl_of(m.aluop, m.imm);
    e.rw   = m.regwrite;
    e.mr   = m.memread;
    e.mw   = m.memwrite;
    e.mt   = m.memtoreg;
    return e;
  endfunction

  // Drive the staged inputs for one cycle, advance the model on the edge and queue the expectation
  task automatic step(input logic r, input logic f, input logic s);
    @(negedge clk);
    d_in  = nx;
    d_fw  = nfw;
    rst   = r;
    flush = f;
    stall = s;
    @(posedge clk);
    if (r || f) model = '0;
    else if (!s) model = d_in;
    sb.push_back(expect_of(model, d_fw));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation, away from the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        chk("alu_a",         alu_a,                 e.a);
        chk("alu_b",         alu_b,                 e.b);
        chk("ex_store_data", ex_store_data,         e.st);
        chk("ex_dest",       32'(ex_dest),          32'(e.dest));
        chk("alu_control",   32'(alu_control),      32'(e.ctl));
        chk("ex_ctrl",       {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg},
                             {28'd0, e.rw, e.mr, e.mw, e.mt});
      end
    end
  end

  function automatic instr_t rand_instr();
    instr_t t;
    logic [31:0] r;
    t.rs_data  = $urandom;
    t.rt_data  = $urandom;
    r          = $urandom;
    t.imm      = r[15:0];
    if (r[16]) t.imm[5:0] = funct_key[$urandom_range(0, 4)];
    t.rs       = 5'($urandom_range(0, 3));
    t.rt       = 5'($urandom_range(0, 3));
    t.rd       = 5'($urandom_range(0, 31));
    t.aluop    = 2'($urandom_range(0, 3));
    t.alusrc   = r[17];
    t.regdst   = r[18];
    t.regwrite = r[19];
    t.memread  = r[20];
    t.memwrite = r[21];
    t.memtoreg = r[22];
    return t;
  endfunction

  function automatic fw_t rand_fw();
    fw_t f;
    f.ex_we  = 1'($urandom_range(0, 1));
    f.ex_rd  = 5'($urandom_range(0, 3));
    f.ex_res = $urandom;
    f.wb_we  = 1'($urandom_range(0, 1));
    f.wb_rd  = 5'($urandom_range(0, 3));
    f.wb_res = $urandom;
    return f;
  endfunction

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    d_in = '0; d_fw = '0; model = '0;

    // Reset with busy inputs: bubble, alu_control = add
    nx  = '{rs_data: 32'hDEAD_BEEF, rt_data: 32'h1234_5678, imm: 16'h8001, rs: 5'd9, rt: 5'd10,
            rd: 5'd11, aluop: 2'd2, alusrc: 1'b1, regdst: 1'b1, regwrite: 1'b1, memread: 1'b1,
            memwrite: 1'b1, memtoreg: 1'b1};
    nfw = '{ex_we: 1'b1, ex_rd: 5'd9, ex_res: 32'h77, wb_we: 1'b1, wb_rd: 5'd10, wb_res: 32'h88};
    step(1, 0, 0);

    // R-type slt
    nfw = '0;
    nx  = '{rs_data: 32'd5, rt_data: 32'd9, imm: 16'h002A, rs: 5'd1, rt: 5'd2, rd: 5'd7,
            aluop: 2'd2, alusrc: 1'b0, regdst: 1'b1, regwrite: 1'b1, memread: 1'b0,
            memwrite: 1'b0, memtoreg: 1'b0};
    step(0, 0, 0);

    // lw with negative offset
    nx  = '{rs_data: 32'd100, rt_data: 32'd3, imm: 16'hFFFC, rs: 5'd4, rt: 5'd6, rd: 5'd8,
            aluop: 2'd0, alusrc: 1'b1, regdst: 1'b0, regwrite: 1'b1, memread: 1'b1,
            memwrite: 1'b0, memtoreg: 1'b1};
    step(0, 0, 0);

    // Forwarding priority: EX/MEM, then MEM/WB, then register 0 never forwards
    nx  = '{rs_data: 32'd1, rt_data: 32'd2, imm: 16'h0020, rs: 5'd3, rt: 5'd12, rd: 5'd13,
            aluop: 2'd2, alusrc: 1'b0, regdst: 1'b1, regwrite: 1'b1, memread: 1'b0,
            memwrite: 1'b0, memtoreg: 1'b0};
    nfw = '{ex_we: 1'b1, ex_rd: 5'd3, ex_res: 32'd7, wb_we: 1'b1, wb_rd: 5'd3, wb_res: 32'd8};
    step(0, 0, 0);
    nfw.ex_we = 1'b0;
    step(0, 0, 1);
    nx.rs = 5'd0; nx.rs_data = 32'h0000_00AB;
    nfw = '{ex_we: 1'b1, ex_rd: 5'd0, ex_res: 32'd7, wb_we: 1'b1, wb_rd: 5'd0, wb_res: 32'd8};
    step(0, 0, 0);

    // sw, then stall twice with changing inputs, then flush+stall gives a bubble
    nfw = '0;
    nx  = '{rs_data: 32'h40, rt_data: 32'h55, imm: 16'h0008, rs: 5'd2, rt: 5'd5, rd: 5'd0,
            aluop: 2'd0, alusrc: 1'b1, regdst: 1'b0, regwrite: 1'b0, memread: 1'b0,
            memwrite: 1'b1, memtoreg: 1'b0};
    step(0, 0, 0);
    nx = rand_instr(); step(0, 0, 1);
    nx = rand_instr(); step(0, 0, 1);
    nx = rand_instr(); step(0, 1, 1);

    // Invalid ALUOp and unknown funct
    nx = rand_instr(); nx.aluop = 2'd3; step(0, 0, 0);
    nx.aluop = 2'd2; nx.imm = 16'h0000; step(0, 0, 0);

    // Reset while stalling still clears
    nx = rand_instr(); step(1, 0, 1);

    // Randomized traffic with occasional stall, flush and reset
    for (int i = 0; i < 400; i++) begin
      nx  = rand_instr();
      nfw = rand_fw();
      step(($urandom_range(0, 99) < 4)  ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0);
    end

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
